// File: rtl/rotary_param_menu.sv
// rotary_param_menu
//   Converts debounced rotary-encoder pulses into a bank of user-adjustable
//   parameter registers. In BROWSE mode, rotation selects a field.
//   In EDIT mode, rotation steps the selected field's value, with
//   acceleration and an idle timeout back to BROWSE. All outputs are
//   registered.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active high
//   left       one-cycle pulse, one counter-clockwise detent
//   right      one-cycle pulse, one clockwise detent
//   down       one-cycle pulse, button pressed
//   lock       level; while high, events are dropped and timers hold
//   field_sel  index of the currently selected field
//   edit_mode  1 = EDIT, 0 = BROWSE
//   values     field i at bits [i*WIDTH +: WIDTH]
//   changed    one-cycle strobe when values or field_sel change
module rotary_param_menu #(
    parameter int unsigned NUM_FIELDS   = 4,
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned INIT_VALUE   = 0,
    parameter int unsigned ACCEL_WINDOW = 2500000,
    parameter int unsigned ACCEL_STEP   = 8,        // must be below 2**WIDTH
    parameter int unsigned TIMEOUT      = 250000000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          left,
    input  logic                          right,
    input  logic                          down,
    input  logic                          lock,
    output logic [$clog2(NUM_FIELDS)-1:0] field_sel,
    output logic                          edit_mode,
    output logic [NUM_FIELDS*WIDTH-1:0]   values,
    output logic                          changed
);

    localparam int unsigned SW = $clog2(NUM_FIELDS);
    localparam int unsigned AW = $clog2(ACCEL_WINDOW + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [SW-1:0]    SelLast  = SW'(NUM_FIELDS - 1);
    localparam logic [AW-1:0]    AccelMax = AW'(ACCEL_WINDOW);
    localparam logic [TW-1:0]    TmoLast  = TW'(TIMEOUT - 1);
    localparam logic [WIDTH:0]   StepFast = (WIDTH + 1)'(ACCEL_STEP);
    localparam logic [WIDTH:0]   StepSlow = (WIDTH + 1)'(1);
    localparam logic [WIDTH-1:0] InitVal  = WIDTH'(INIT_VALUE);

    typedef enum logic {StBrowse, StEdit} mode_e;
    typedef enum logic [1:0] {DirNone, DirUp, DirDown} dir_e;

    mode_e            mode_q;
    dir_e             last_dir_q;
    logic [SW-1:0]    sel_q;
    logic [WIDTH-1:0] field_q [NUM_FIELDS];
    logic [AW-1:0]    accel_q;
    logic [TW-1:0]    tmo_q;
    logic             changed_q;

    logic             ev_down;
    logic             ev_rot;
    dir_e             ev_dir;
    logic [WIDTH:0]   cur_val;
    logic [WIDTH:0]   step;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] new_val;

    // Event qualification and the saturating edit arithmetic.
    always_comb begin
        ev_down = ~lock & down;
        // Press wins over rotation; opposing rotations cancel.
        ev_rot  = ~lock & ~down & (left ^ right);
        ev_dir  = right ? DirUp : DirDown;
        cur_val = {1'b0, field_q[sel_q]};
        step    = ((last_dir_q == ev_dir) && (accel_q < AccelMax)) ? StepFast : StepSlow;
        sum     = cur_val + step;
        diff    = cur_val - step;
        // Top bit of the WIDTH+1 result is the carry out / borrow.
        if (right) begin
            new_val = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        end else begin
            new_val = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= StBrowse;
            last_dir_q <= DirNone;
            sel_q      <= '0;
            accel_q    <= '0;
            tmo_q      <= '0;
            changed_q  <= 1'b0;
            for (int i = 0; i < NUM_FIELDS; i++) begin
                field_q[i] <= InitVal;
            end
        end else begin
            changed_q <= 1'b0;
            if (!lock) begin
                // Cycles since the last edit step; saturates so it never wraps.
                if (accel_q != AccelMax) begin
                    accel_q <= accel_q + AW'(1);
                end
                unique case (mode_q)
                    StBrowse: begin
                        if (ev_down) begin
                            mode_q     <= StEdit;
                            tmo_q      <= '0;
                            accel_q    <= '0;
                            last_dir_q <= DirNone;
                        end else if (ev_rot) begin
                            changed_q <= 1'b1;
                            if (right) begin
                                sel_q <= (sel_q == SelLast) ? '0 : sel_q + SW'(1);
                            end else begin
                                sel_q <= (sel_q == '0) ? SelLast : sel_q - SW'(1);
                            end
                        end
                    end
                    StEdit: begin
                        if (ev_down) begin
                            mode_q <= StBrowse;
                            tmo_q  <= '0;
                        end else if (ev_rot) begin
                            field_q[sel_q] <= new_val;
                            changed_q      <= (new_val != field_q[sel_q]);
                            accel_q        <= '0;
                            last_dir_q     <= ev_dir;
                            tmo_q          <= '0;
                        end else if (tmo_q == TmoLast) begin
                            mode_q <= StBrowse;
                            tmo_q  <= '0;
                        end else begin
                            tmo_q <= tmo_q + TW'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign field_sel = sel_q;
    assign edit_mode = (mode_q == StEdit);
    assign changed   = changed_q;

    for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_values
        assign values[i*WIDTH +: WIDTH] = field_q[i];
    end

endmodule

// File: tb/tb_rotary_param_menu.sv
// Testbench for rotary_param_menu: directed sequences followed by random
// input traffic, all checked through a scoreboard fed by a reference model.
module tb_rotary_param_menu;

    localparam int NF    = 4;
    localparam int W     = 8;
    // Window shorter than the timeout, so slow steps fit in one EDIT session.
    localparam int AWIN  = 40;
    localparam int ASTEP = 8;
    localparam int TMO   = 100;
    localparam int VMAX  = 255;

    logic            clk = 1'b0;
    logic            rst;
    logic            left, right, down, lock;
    logic [1:0]      field_sel;
    logic            edit_mode;
    logic [NF*W-1:0] values;
    logic            changed;

    always #5 clk = ~clk;

    rotary_param_menu #(
        .NUM_FIELDS  (NF),
        .WIDTH       (W),
        .INIT_VALUE  (0),
        .ACCEL_WINDOW(AWIN),
        .ACCEL_STEP  (ASTEP),
        .TIMEOUT     (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .left     (left),
        .right    (right),
        .down     (down),
        .lock     (lock),
        .field_sel(field_sel),
        .edit_mode(edit_mode),
        .values   (values),
        .changed  (changed)
    );

    typedef struct packed {
        logic [1:0]      sel;
        logic            edit;
        logic            chg;
        logic [NF*W-1:0] vals;
    } snap_t;

    snap_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    // Reference model: menu state kept as plain integers. Acceleration is
    // judged from the number of unlocked cycles elapsed between edit steps.
    int     m_sel;
    bit     m_edit;
    int     m_val[NF];
    int     m_last_dir;   // 0 none, +1 right, -1 left
    longint m_tick;       // unlocked cycle index
    longint m_last_tick;
    int     m_idle;       // unlocked idle cycles in EDIT

    function automatic void model_reset();
        m_sel = 0;
        m_edit = 1'b0;
        for (int i = 0; i < NF; i++) m_val[i] = 0;
        m_last_dir = 0;
        m_tick = 0;
        m_last_tick = 0;
        m_idle = 0;
    endfunction

    function automatic snap_t model_step(input bit l, input bit r, input bit d, input bit k);
        snap_t  s;
        bit     chg = 1'b0;
        int     dir, stp, nv;
        longint gap;
        if (!k) begin
            m_tick++;
            dir = r ? 1 : -1;
            if (d) begin
                if (!m_edit) begin
                    m_edit = 1'b1;
                    m_last_dir = 0;
                end else begin
                    m_edit = 1'b0;
                end
                m_idle = 0;
            end else if (l != r) begin
                if (!m_edit) begin
                    m_sel = (m_sel + dir + NF) % NF;
                    chg = 1'b1;
                end else begin
                    gap = m_tick - m_last_tick - 1;
                    stp = (dir == m_last_dir && gap < AWIN) ? ASTEP : 1;
                    nv = m_val[m_sel] + dir * stp;
                    if (nv < 0) nv = 0;
                    if (nv > VMAX) nv = VMAX;
                    chg = (nv != m_val[m_sel]);
                    m_val[m_sel] = nv;
                    m_last_dir = dir;
                    m_last_tick = m_tick;
                    m_idle = 0;
                end
            end else if (m_edit) begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_edit = 1'b0;
                    m_idle = 0;
                end
            end
        end
        s.sel  = 2'(m_sel);
        s.edit = m_edit;
        s.chg  = chg;
        for (int i = 0; i < NF; i++) s.vals[i*W +: W] = 8'(m_val[i]);
        return s;
    endfunction

    // Called at a falling edge: drive one cycle of inputs, queue the
    // expected outputs after the coming rising edge, then wait a cycle.
    task automatic cycle(input bit l, input bit r, input bit d);
        left  = l;
        right = r;
        down  = d;
        exp_q.push_back(model_step(l, r, d, lock));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: every rising edge that has a queued expectation is compared.
    initial begin
        snap_t e;
        snap_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {field_sel, edit_mode, changed, values};
                n_checks++;
                if (a === e) n_pass++;
                else $display("FAIL scoreboard t=%0t: got sel=%0d edit=%0b changed=%0b values=%h, expected sel=%0d edit=%0b changed=%0b values=%h",
                              $time, a.sel, a.edit, a.chg, a.vals, e.sel, e.edit, e.chg, e.vals);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int unsigned p;
        rst = 1'b1;
        left = 1'b0;
        right = 1'b0;
        down = 1'b0;
        lock = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset field_sel", 64'(field_sel), 0);
        check("reset edit_mode", 64'(edit_mode), 0);
        check("reset values", 64'(values), 0);
        check("reset changed", 64'(changed), 0);
        rst = 1'b0;

        // BROWSE: 1,2,3 then wrap to 0, then left wraps to 3.
        repeat (3) begin cycle(0, 1, 0); idle(2); end
        cycle(0, 1, 0); idle(1);
        cycle(1, 0, 0); idle(1);

        // Acceleration on field 0: 1, 9 (fast), 10 (window expired).
        cycle(0, 1, 0);
        cycle(0, 0, 1);
        cycle(0, 1, 0); idle(10);
        cycle(0, 1, 0); idle(60);
        cycle(0, 1, 0);
        cycle(0, 0, 1);

        // Simultaneous inputs: press beats rotation; opposing turns cancel.
        cycle(0, 1, 1); idle(2);
        cycle(1, 1, 0); idle(2);
        cycle(0, 0, 1);
        cycle(1, 1, 0); idle(2);

        // Lower saturation on field 3: 1, 2, 1, 0, 0 (no strobe).
        cycle(1, 0, 0);
        cycle(0, 0, 1);
        cycle(0, 1, 0); idle(60);
        cycle(0, 1, 0);
        cycle(1, 0, 0); idle(60);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 1);

        // Upper saturation on field 2: up to 254, then fast steps pin at 255.
        cycle(1, 0, 0);
        cycle(0, 0, 1);
        cycle(0, 1, 0);
        repeat (31) begin idle(2); cycle(0, 1, 0); end
        repeat (5) begin idle(60); cycle(0, 1, 0); end
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        cycle(0, 0, 1);

        // Idle timeout back to BROWSE.
        cycle(0, 0, 1);
        idle(110);

        // Lock holds everything, including the timeout.
        cycle(0, 0, 1);
        lock = 1'b1;
        repeat (200) cycle(1'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0));
        lock = 1'b0;
        idle(110);

        // Field 1 to 37 in EDIT, then asynchronous reset mid-cycle.
        cycle(1, 0, 0);
        cycle(0, 0, 1);
        cycle(0, 1, 0);
        repeat (4) begin idle(2); cycle(0, 1, 0); end
        repeat (4) begin idle(60); cycle(0, 1, 0); end
        idle(3);
        #2 rst = 1'b1;
        #1;
        check("async reset field_sel", 64'(field_sel), 0);
        check("async reset edit_mode", 64'(edit_mode), 0);
        check("async reset values", 64'(values), 0);
        check("async reset changed", 64'(changed), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) lock = ~lock;
            p = $urandom_range(0, 99);
            if (p < 10)      cycle(1, 0, 0);
            else if (p < 22) cycle(0, 1, 0);
            else if (p < 25) cycle(0, 0, 1);
            else if (p < 27) cycle(1, 1, 0);
            else if (p < 29) cycle(1, 0, 1);
            else             cycle(0, 0, 0);
        end
        lock = 1'b0;
        idle(2);

        check("scoreboard drained", 64'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
